// File: rtl/route_sequencer_if.sv
// Bundle of the route sequencer's sensor, route-load, control and motor-side signals.
// The master drives sensors, loads and commands; the slave is the sequencer itself.
interface route_sequencer_if;
    logic [2:0] ip_from_ls;
    logic       load_valid;
    logic [1:0] load_dir;
    logic       load_ready;
    logic       start;
    logic       abort;
    logic [1:0] directions;
    logic [7:0] current_node;
    logic       stop_signal;
    logic       busy;
    logic       done;
    logic       fault;

    modport master (
        output ip_from_ls, load_valid, load_dir, start, abort,
        input  load_ready, directions, current_node, stop_signal, busy, done, fault
    );

    modport slave (
        input  ip_from_ls, load_valid, load_dir, start, abort,
        output load_ready, directions, current_node, stop_signal, busy, done, fault
    );
endinterface

// File: rtl/route_sequencer.sv
// Line-following route sequencer: queues turn codes, debounces node crossings and steps the route.
// Optional lost-line detection (FAULT state) is enabled by defining ROUTE_SEQUENCER_LOST_LINE_EN.
module route_sequencer #(
    parameter int DEPTH        = 16,
    parameter int DEBOUNCE     = 50000,
    parameter int HOLDOFF      = 25000000,
    parameter int LOST_TIMEOUT = 50000000
) (
    input logic             clk,
    input logic             rst,
    route_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMAX  = (DEBOUNCE > HOLDOFF) ? DEBOUNCE : HOLDOFF;
    localparam int TMR_W = $clog2(TMAX + 1);

    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("route_sequencer: DEPTH must be a power of two in 2..64");
    end
    if (DEBOUNCE < 1 || HOLDOFF < 0 || LOST_TIMEOUT < 1) begin : g_bad_timing
        $error("route_sequencer: DEBOUNCE and LOST_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_DEBOUNCE,
        S_HOLD,
        S_STOPPED
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
        , S_FAULT
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [TMR_W-1:0]  timer_reg, timer_next;
    logic [1:0]        dir_reg, dir_next;
    logic [7:0]        node_reg, node_next;
    logic              stop_reg, stop_next;
    logic              done_reg, done_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [1:0]        fifo_mem [DEPTH];

    logic load_ready;
    logic push;
    logic pop;
    logic node_event;

`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
    localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);
    localparam logic [LOST_W-1:0] LOST_ONE  = LOST_W'(1);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
    logic [LOST_W-1:0] lost_reg, lost_next;
    logic              fault_reg, fault_next;
    assign bus.fault = fault_reg;
`else
    assign bus.fault = 1'b0;
`endif

    assign load_ready = ((state_reg == S_IDLE) || (state_reg == S_STOPPED)) && (count_reg < CNT_FULL);

    assign bus.load_ready   = load_ready;
    assign bus.directions   = dir_reg;
    assign bus.current_node = node_reg;
    assign bus.stop_signal  = stop_reg;
    assign bus.done         = done_reg;
    assign bus.busy         = (state_reg == S_TRACK) || (state_reg == S_DEBOUNCE) || (state_reg == S_HOLD);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        dir_next   = dir_reg;
        node_next  = node_reg;
        stop_next  = stop_reg;
        done_next  = 1'b0;
        push       = bus.load_valid && load_ready;
        pop        = 1'b0;
        node_event = 1'b0;
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
        lost_next  = '0;
        fault_next = fault_reg;
`endif

        case (state_reg)
            S_IDLE, S_STOPPED: begin
                // Occupancy is judged before this cycle's write, so start+load on an empty queue does nothing.
                if (bus.start && count_reg != '0) begin
                    state_next = S_TRACK;
                    node_next  = 8'd0;
                    dir_next   = 2'b00;
                    stop_next  = 1'b0;
                    timer_next = '0;
                end
            end
            S_TRACK: begin
                if (bus.ip_from_ls == 3'b111) begin
                    if (DEBOUNCE <= 1) begin
                        node_event = 1'b1;
                    end else begin
                        state_next = S_DEBOUNCE;
                        timer_next = TMR_ONE;
                    end
                end
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
                else if (bus.ip_from_ls == 3'b000) begin
                    if (lost_reg == LOST_LAST) begin
                        state_next = S_FAULT;
                        fault_next = 1'b1;
                        stop_next  = 1'b1;
                        dir_next   = 2'b00;
                    end else begin
                        lost_next = lost_reg + LOST_ONE;
                    end
                end
`endif
            end
            S_DEBOUNCE: begin
                if (bus.ip_from_ls == 3'b111) begin
                    if (timer_reg == DEB_LAST) begin
                        node_event = 1'b1;
                    end else begin
                        timer_next = timer_reg + TMR_ONE;
                    end
                end else begin
                    state_next = S_TRACK;
                    timer_next = '0;
                end
            end
            S_HOLD: begin
                if (timer_reg == HOLD_LAST) begin
                    state_next = S_TRACK;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TMR_ONE;
                end
            end
            default: ;
        endcase

        if (node_event) begin
            node_next  = node_reg + 8'd1;
            timer_next = '0;
            if (count_reg != '0) begin
                pop        = 1'b1;
                dir_next   = fifo_mem[rd_ptr_reg];
                state_next = (HOLDOFF > 0) ? S_HOLD : S_TRACK;
            end else begin
                dir_next   = 2'b00;
                stop_next  = 1'b1;
                done_next  = 1'b1;
                state_next = S_STOPPED;
            end
        end

        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);

        // Abort wins over everything else this cycle, including a pending load or node event.
        if (bus.abort) begin
            state_next  = S_IDLE;
            timer_next  = '0;
            dir_next    = 2'b00;
            stop_next   = 1'b1;
            done_next   = 1'b0;
            node_next   = node_reg;
            push        = 1'b0;
            pop         = 1'b0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
            lost_next   = '0;
            fault_next  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            timer_reg  <= '0;
            dir_reg    <= 2'b00;
            node_reg   <= 8'd0;
            stop_reg   <= 1'b1;
            done_reg   <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
            lost_reg   <= '0;
            fault_reg  <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            dir_reg    <= dir_next;
            node_reg   <= node_next;
            stop_reg   <= stop_next;
            done_reg   <= done_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
            lost_reg   <= lost_next;
            fault_reg  <= fault_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr_reg] <= bus.load_dir;
        end
    end
endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer: directed route scenarios followed by random traffic,
// every cycle compared against a queue-based route model.
module tb_route_sequencer;
    localparam int DEPTH = 16;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int LOST  = 10;
`ifdef ROUTE_SEQUENCER_LOST_LINE_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HOLD  = 2;
    localparam int M_STOP  = 3;
    localparam int M_FAULT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    route_sequencer_if bus_if ();

    route_sequencer #(
        .DEPTH(DEPTH), .DEBOUNCE(DEB), .HOLDOFF(HOLD), .LOST_TIMEOUT(LOST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Route model: mode, length of current 111 run, hold cycles left, 000 run, queued turns.
    int         m_mode;
    int         m_run;
    int         m_hold;
    int         m_zeros;
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    logic [7:0] m_node;
    bit         m_stop, m_done, m_fault;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_run = 0; m_hold = 0; m_zeros = 0;
        m_q.delete();
        m_dir = 2'b00; m_node = 8'd0; m_stop = 1'b1; m_done = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] s, input logic lv, input logic [1:0] ld,
                              input logic st, input logic ab, input logic r);
        bit ready;
        bit node_hit;
        int had;
        if (r) begin
            model_reset();
            return;
        end
        ready    = (m_mode == M_IDLE || m_mode == M_STOP) && (m_q.size() < DEPTH);
        had      = m_q.size();
        m_done   = 1'b0;
        node_hit = 1'b0;
        if (ab) begin
            m_mode = M_IDLE; m_q.delete(); m_dir = 2'b00; m_stop = 1'b1; m_fault = 1'b0;
            m_run = 0; m_zeros = 0;
            return;
        end
        case (m_mode)
            M_IDLE, M_STOP: begin
                if (st && had > 0) begin
                    m_mode = M_RUN; m_node = 8'd0; m_dir = 2'b00; m_stop = 1'b0;
                    m_run = 0; m_zeros = 0;
                end
            end
            M_RUN: begin
                if (s == 3'b111) begin
                    m_run++;
                    m_zeros = 0;
                    if (m_run == DEB) node_hit = 1'b1;
                end else begin
                    if (m_run > 0) begin
                        m_run = 0; m_zeros = 0;
                    end else if (s == 3'b000) begin
                        m_zeros++;
                    end else begin
                        m_zeros = 0;
                    end
                    if (LOST_EN && m_zeros == LOST) begin
                        m_mode = M_FAULT; m_stop = 1'b1; m_dir = 2'b00; m_fault = 1'b1;
                    end
                end
            end
            M_HOLD: begin
                m_hold--;
                if (m_hold == 0) begin
                    m_mode = M_RUN; m_run = 0; m_zeros = 0;
                end
            end
            default: ;
        endcase
        if (node_hit) begin
            m_node = m_node + 8'd1;
            m_run = 0;
            if (m_q.size() > 0) begin
                m_dir = m_q.pop_front();
                m_mode = M_HOLD;
                m_hold = HOLD;
            end else begin
                m_dir = 2'b00; m_stop = 1'b1; m_done = 1'b1; m_mode = M_STOP;
            end
            $display("node %0d reached, directions %0d, done %0d", m_node, m_dir, m_done);
        end
        if (ready && lv) m_q.push_back(ld);
    endtask

    task automatic compare_all();
        check("load_ready", bus_if.load_ready,
              ((m_mode == M_IDLE || m_mode == M_STOP) && m_q.size() < DEPTH) ? 1 : 0);
        check("directions", bus_if.directions, m_dir);
        check("current_node", bus_if.current_node, m_node);
        check("stop_signal", bus_if.stop_signal, m_stop);
        check("busy", bus_if.busy, (m_mode == M_RUN || m_mode == M_HOLD) ? 1 : 0);
        check("done", bus_if.done, m_done);
        check("fault", bus_if.fault, m_fault);
    endtask

    task automatic step(input logic [2:0] s, input logic lv, input logic [1:0] ld,
                        input logic st, input logic ab, input logic r);
        bus_if.ip_from_ls = s;
        bus_if.load_valid = lv;
        bus_if.load_dir   = ld;
        bus_if.start      = st;
        bus_if.abort      = ab;
        rst               = r;
        @(posedge clk);
        model_edge(s, lv, ld, st, ab, r);
        #1;
        if (bus_if.done === 1'b1) done_seen++;
        compare_all();
    endtask

    task automatic sense(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [1:0] d);
        step(3'b010, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go();
        step(3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_abort();
        step(3'b010, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    logic [1:0] burst_dir [3];
    logic [2:0] pat;
    int         pat_left;
    int         done_before;
    int         sel;

    initial begin
        model_reset();
        bus_if.ip_from_ls = 3'b010;
        bus_if.load_valid = 1'b0;
        bus_if.load_dir   = 2'b00;
        bus_if.start      = 1'b0;
        bus_if.abort      = 1'b0;
        rst               = 1'b1;

        // Reset state
        step(3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        sense(3'b010, 1);
        check("rst_load_ready", bus_if.load_ready, 1);
        check("rst_stop", bus_if.stop_signal, 1);

        // Three clean nodes over a two-entry route
        burst_dir[0] = 2'b01; burst_dir[1] = 2'b10; burst_dir[2] = 2'b00;
        load(2'b01);
        load(2'b10);
        go();
        check("start_busy", bus_if.busy, 1);
        done_before = done_seen;
        for (int b = 0; b < 3; b++) begin
            sense(3'b010, 12);
            sense(3'b111, 4);
            check("burst_node", bus_if.current_node, b + 1);
            check("burst_dir", bus_if.directions, burst_dir[b]);
        end
        check("route_done_pulses", done_seen - done_before, 1);
        check("route_stop", bus_if.stop_signal, 1);
        check("route_busy", bus_if.busy, 0);

        // Short glitch, then a real node, then 111 during hold-off
        load(2'b01);
        load(2'b11);
        go();
        sense(3'b111, 3);
        sense(3'b010, 5);
        check("glitch_node", bus_if.current_node, 0);
        sense(3'b111, 4);
        check("after_glitch_node", bus_if.current_node, 1);
        sense(3'b111, 6);
        sense(3'b010, 5);
        check("hold_ignore_node", bus_if.current_node, 1);
        check("hold_ignore_dir", bus_if.directions, 1);

        // Reset in HOLD after node 1
        do_abort();
        load(2'b01);
        go();
        sense(3'b111, 4);
        sense(3'b010, 2);
        step(3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("rsthold_node", bus_if.current_node, 0);
        check("rsthold_dir", bus_if.directions, 0);
        check("rsthold_busy", bus_if.busy, 0);
        check("rsthold_ready", bus_if.load_ready, 1);

        // Abort in TRACK, then start with an empty queue
        load(2'b10);
        go();
        sense(3'b010, 3);
        done_before = done_seen;
        do_abort();
        check("abort_busy", bus_if.busy, 0);
        check("abort_stop", bus_if.stop_signal, 1);
        go();
        sense(3'b111, 5);
        check("empty_start_busy", bus_if.busy, 0);
        check("abort_no_done", done_seen - done_before, 0);

        // Fill past capacity
        for (int i = 0; i < 17; i++) begin
            load(2'(i));
            if (i == 15) check("full_ready", bus_if.load_ready, 0);
        end
        check("overfill_ready", bus_if.load_ready, 0);
        do_abort();
        check("flushed_ready", bus_if.load_ready, 1);

        // Lost line: 10 zeros, then 9 zeros followed by 010
        load(2'b01);
        go();
        sense(3'b000, 10);
        check("lost10_fault", bus_if.fault, LOST_EN);
        check("lost10_stop", bus_if.stop_signal, LOST_EN);
        do_abort();
        check("lost_abort_fault", bus_if.fault, 0);
        load(2'b01);
        go();
        sense(3'b000, 9);
        sense(3'b010, 1);
        sense(3'b000, 1);
        check("lost9_fault", bus_if.fault, 0);
        do_abort();

        // Random traffic
        pat = 3'b010;
        pat_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (pat_left == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 5) begin
                    pat = 3'b010; pat_left = $urandom_range(1, 12);
                end else if (sel < 8) begin
                    pat = 3'b111; pat_left = $urandom_range(1, 6);
                end else if (sel == 8) begin
                    pat = 3'b000; pat_left = $urandom_range(1, 12);
                end else begin
                    pat = 3'($urandom_range(0, 7)); pat_left = $urandom_range(1, 3);
                end
            end
            pat_left--;
            step(pat,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
